// File: rtl/gelato_inst_fetch_mo_if.sv
// Bundle of the fetch unit's handshakes: scheduler PC channel, I-cache
// request/response, decode output, warp flush and status signals.
interface gelato_inst_fetch_mo_if #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int WARP_W  = 5,
    parameter int SPLIT_W = 4,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = $clog2(DEPTH),
    parameter int CNT_W   = $clog2(DEPTH + 1)
);
    logic               rdy;
    // scheduler -> fetch
    logic               pc_valid;
    logic               pc_ready;
    logic [ADDR_W-1:0]  pc;
    logic [WARP_W-1:0]  pc_warp;
    logic [SPLIT_W-1:0] pc_split;
    // fetch -> I-cache
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic [TAG_W-1:0]   req_tag;
    // I-cache -> fetch
    logic               resp_valid;
    logic [TAG_W-1:0]   resp_tag;
    logic [INST_W-1:0]  resp_data;
    // fetch -> decode
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [WARP_W-1:0]  out_warp;
    logic [SPLIT_W-1:0] out_split;
    logic [INST_W-1:0]  out_inst;
    // warp squash
    logic               flush_valid;
    logic [WARP_W-1:0]  flush_warp;
    // status
    logic [CNT_W-1:0]   outstanding;
    logic               err_spurious;

    // Fetch unit side.
    modport master (
        input  rdy, pc_valid, pc, pc_warp, pc_split, req_ready,
               resp_valid, resp_tag, resp_data, out_ready, flush_valid, flush_warp,
        output pc_ready, req_valid, req_addr, req_tag, out_valid, out_pc,
               out_warp, out_split, out_inst, outstanding, err_spurious
    );

    // Surrounding pipeline side.
    modport slave (
        output rdy, pc_valid, pc, pc_warp, pc_split, req_ready,
               resp_valid, resp_tag, resp_data, out_ready, flush_valid, flush_warp,
        input  pc_ready, req_valid, req_addr, req_tag, out_valid, out_pc,
               out_warp, out_split, out_inst, outstanding, err_spurious
    );
endinterface

// File: rtl/gelato_inst_fetch_mo.sv
// Multi-outstanding instruction fetch with an in-order reorder table.
// The slot index doubles as the I-cache tag; responses may return in any
// order and are released to decode strictly from the head slot.
module gelato_inst_fetch_mo #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int WARP_W  = 5,
    parameter int SPLIT_W = 4,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    gelato_inst_fetch_mo_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Per-slot state gathered into vectors/arrays for head/tag indexing.
    logic [DEPTH-1:0]   slot_valid;
    logic [DEPTH-1:0]   slot_done;
    logic [DEPTH-1:0]   slot_killed;
    logic [ADDR_W-1:0]  slot_pc    [DEPTH];
    logic [WARP_W-1:0]  slot_warp  [DEPTH];
    logic [SPLIT_W-1:0] slot_split [DEPTH];
    logic [INST_W-1:0]  slot_inst  [DEPTH];

    logic [TAG_W-1:0]  head_reg;
    logic [TAG_W-1:0]  tail_reg;
    logic              req_valid_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [TAG_W-1:0]  req_tag_reg;
    logic [CNT_W-1:0]  outstanding_reg;
    logic              err_reg;

    logic full;
    logic pc_ready;
    logic alloc;
    logic alloc_killed;
    logic head_valid;
    logic head_done;
    logic head_killed;
    logic out_valid;
    logic retire;
    logic resp_hit;

    // Full, allocate, retire and response-hit decisions from registered state.
    always_comb begin
        full         = &slot_valid;
        pc_ready     = bus.rdy && !full && (!req_valid_reg || bus.req_ready);
        alloc        = bus.pc_valid && pc_ready;
        alloc_killed = bus.flush_valid && (bus.pc_warp == bus.flush_warp);
        head_valid   = slot_valid[head_reg];
        head_done    = slot_done[head_reg];
        head_killed  = slot_killed[head_reg];
        out_valid    = bus.rdy && head_valid && head_done && !head_killed;
        // killed entries drain without a decode handshake
        retire       = bus.rdy && head_valid && head_done && (head_killed || bus.out_ready);
        resp_hit     = bus.resp_valid && slot_valid[bus.resp_tag] && !slot_done[bus.resp_tag];
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic               valid_reg;
            logic               done_reg;
            logic               killed_reg;
            logic [ADDR_W-1:0]  pc_reg;
            logic [WARP_W-1:0]  warp_reg;
            logic [SPLIT_W-1:0] split_reg;
            logic [INST_W-1:0]  inst_reg;

            logic is_tail;
            logic is_head;
            logic is_resp;
            assign is_tail = (tail_reg == TAG_W'(gi));
            assign is_head = (head_reg == TAG_W'(gi));
            assign is_resp = (bus.resp_tag == TAG_W'(gi));

            // Slot status: allocate at tail, free at head, mark done/killed otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg  <= 1'b0;
                    done_reg   <= 1'b0;
                    killed_reg <= 1'b0;
                end else if (alloc && is_tail) begin
                    valid_reg  <= 1'b1;
                    done_reg   <= 1'b0;
                    killed_reg <= alloc_killed;
                end else if (retire && is_head) begin
                    valid_reg  <= 1'b0;
                    done_reg   <= 1'b0;
                    killed_reg <= 1'b0;
                end else begin
                    if (resp_hit && is_resp) begin
                        done_reg <= 1'b1;
                    end
                    if (bus.flush_valid && valid_reg && (warp_reg == bus.flush_warp)) begin
                        killed_reg <= 1'b1;
                    end
                end
            end

            // Slot payload: request fields at allocation, instruction on response.
            always_ff @(posedge clk) begin
                if (alloc && is_tail) begin
                    pc_reg    <= bus.pc;
                    warp_reg  <= bus.pc_warp;
                    split_reg <= bus.pc_split;
                end
                if (resp_hit && is_resp) begin
                    inst_reg <= bus.resp_data;
                end
            end

            assign slot_valid[gi]  = valid_reg;
            assign slot_done[gi]   = done_reg;
            assign slot_killed[gi] = killed_reg;
            assign slot_pc[gi]     = pc_reg;
            assign slot_warp[gi]   = warp_reg;
            assign slot_split[gi]  = split_reg;
            assign slot_inst[gi]   = inst_reg;
        end
    endgenerate

    // Pointers, request register, occupancy counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            req_valid_reg   <= 1'b0;
            req_addr_reg    <= '0;
            req_tag_reg     <= '0;
            outstanding_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            if (alloc) begin
                tail_reg <= tail_reg + TAG_W'(1);
            end
            if (retire) begin
                head_reg <= head_reg + TAG_W'(1);
            end
            // request holds until the cache takes it; a new fire replaces it
            if (!req_valid_reg || bus.req_ready) begin
                req_valid_reg <= alloc;
                if (alloc) begin
                    req_addr_reg <= bus.pc;
                    req_tag_reg  <= tail_reg;
                end
            end
            outstanding_reg <= outstanding_reg + CNT_W'(alloc) - CNT_W'(retire);
            if (bus.resp_valid && !resp_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.pc_ready     = pc_ready;
    assign bus.req_valid    = req_valid_reg;
    assign bus.req_addr     = req_addr_reg;
    assign bus.req_tag      = req_tag_reg;
    assign bus.out_valid    = out_valid;
    assign bus.out_pc       = slot_pc[head_reg];
    assign bus.out_warp     = slot_warp[head_reg];
    assign bus.out_split    = slot_split[head_reg];
    assign bus.out_inst     = slot_inst[head_reg];
    assign bus.outstanding  = outstanding_reg;
    assign bus.err_spurious = err_reg;
endmodule

// File: doc/gelato_inst_fetch_mo.md
Name: gelato_inst_fetch_mo

Overview:
Multi-outstanding instruction fetch unit. It sits between the fetch scheduler (PC source) and the decode stage, and issues up to DEPTH tagged I-cache reads back-to-back. Responses may return out of order; the unit reorders them and delivers instructions to decode strictly in request order. It supports per-warp flush, which squashes in-flight fetches of a redirected or diverged warp.

Parameters:
ADDR_W, 32, PC/address width
INST_W, 32, instruction word width
WARP_W, 5, warp number width
SPLIT_W, 4, split-table index width
DEPTH, 4, max outstanding fetches; power of 2, >=2
TAG_W, $clog2(DEPTH), cache request tag width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
rdy  in  1  global enable; 0 = stall
pc_valid  in  1  fetch request from scheduler
pc_ready  out  1  request accepted when valid&&ready
pc  in  ADDR_W  fetch PC
pc_warp  in  WARP_W  warp number
pc_split  in  SPLIT_W  split-table number
req_valid  out  1  I-cache read request
req_ready  in  1  I-cache accepts request
req_addr  out  ADDR_W  read address
req_tag  out  TAG_W  slot tag
resp_valid  in  1  I-cache response (no backpressure)
resp_tag  in  TAG_W  response tag
resp_data  in  INST_W  instruction word
out_valid  out  1  instruction to decode
out_ready  in  1  decode accepts
out_pc  out  ADDR_W  PC of instruction
out_warp  out  WARP_W  warp number
out_split  out  SPLIT_W  split-table number
out_inst  out  INST_W  instruction word
flush_valid  in  1  squash warp
flush_warp  in  WARP_W  warp to squash
outstanding  out  $clog2(DEPTH+1)  occupied slots
err_spurious  out  1  sticky: illegal response seen

Behaviour:
- Reorder table: DEPTH slots {valid, done, killed, pc, warp, split, inst}, with head/tail pointers of TAG_W bits that wrap modulo DEPTH. Full is declared when all slots are valid. The slot index is the tag.
- Reset: all slots invalid, head=tail=0, req_valid=0, out_valid=0, outstanding=0, err_spurious=0. A reset mid-operation discards all state. Responses arriving afterwards are treated as spurious.
- Allocate:
  - pc_ready = rdy && !full && (!req_valid || req_ready).
  - On fire, slot[tail] gets valid=1, done=0, killed=0, and the PC/warp/split fields; tail increments.
  - Next cycle, req_valid=1, req_addr=pc, req_tag=old tail.
  - req_valid and its fields hold until req_ready. Back-to-back fires sustain one request per cycle.
- Response:
  - resp_valid with slot[resp_tag].valid && !done sets done=1 and inst=resp_data, regardless of killed.
  - A response to an invalid or already-done slot is ignored and sets err_spurious (sticky until reset).
  - Responses and flushes are accepted even when rdy=0.
- Output:
  - out_valid = rdy && slot[head].valid && done && !killed. The out_* fields come combinationally from slot[head].
  - On out_valid && out_ready: clear the slot and increment head.
  - A head slot that is done && killed is retired silently in one cycle without asserting out_valid.
  - At most one retirement occurs per cycle.
- Flush: flush_valid sets killed on every valid slot whose warp==flush_warp, effective next cycle.
  - A same-cycle allocation with pc_warp==flush_warp is allocated with killed=1.
  - An output handshake in the flush cycle completes normally.
  - A killed slot still waits for its response before it frees; its issued or pending request is not cancelled.
- Simultaneous events: allocate, response, and retire in the same cycle are all honoured.
  - A slot freed at head is not reusable in the same cycle, because full is evaluated from registered state.
  - outstanding = previous value + alloc − retire.
- Order guarantee: the out_* sequence equals the accepted PC order minus killed entries.

Test Plan:
- Single fetch: pc=0x100, warp=3, split=1; cache returns tag 0 with data 0xDEADBEEF after 2 cycles -> req_addr=0x100/tag 0; out_valid with out_inst=0xDEADBEEF, out_pc=0x100, warp 3, split 1; outstanding returns 0.
- Fill/full: 4 PCs (0x0,0x4,0x8,0xC) with no responses -> tags 0..3 issued, pc_ready=0 after the 4th, outstanding=4. One retire re-enables pc_ready the next cycle, and the next tag is 0 (wrap).
- Out-of-order: responses for tags 2,0,3,1 -> outputs delivered in PC order 0x0,0x4,0x8,0xC. out_valid first rises only after tag 0 returns.
- Flush: warps 1,2,1 in flight; flush_warp=1 -> only the warp-2 instruction is output. outstanding drops to 0 after all 3 responses arrive. Also check a same-cycle allocation of warp 1 during the flush is killed.
- Backpressure/stall: hold req_ready=0 for 3 cycles -> req_addr/req_tag remain stable. Hold out_ready=0, then rdy=0 -> no output, but responses are still captured; deassertion resumes delivery in order.
- Spurious and reset: a response to a free tag sets err_spurious=1. Asserting rst_n low with 2 fetches outstanding clears everything, and a later response sets err_spurious again.
